tile_dispatch_writer: RTL and testbench

- Write-side engine for the tile BRAM (L1): the DISPATCH producer that drives its four line-based write ports.
- Accepts a command giving a side, a start line address and a line count.
- Consumes a valid/ready stream of beats, each beat a mantissa line plus its exponent byte.
- Issues one registered mantissa write and one exponent write per beat, at consecutive line addresses, on the selected side.

---
 rtl/tile_dispatch_writer.sv | 149 ++++++++++++++
 tb/tb_tile_dispatch_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_dispatch_writer.sv
// DISPATCH-side write engine for the tile L1 BRAM: streams a command's worth of
// mantissa/exponent line beats onto the left or right write ports at consecutive lines.
module tile_dispatch_writer #(
  parameter int MAN_WIDTH  = 256,
  parameter int EXP_WIDTH  = 8,
  parameter int BRAM_DEPTH = 512,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_side,
  input  logic [ADDR_WIDTH-1:0] i_cmd_start_addr,
  input  logic [ADDR_WIDTH:0]   i_cmd_num_lines,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  input  logic [MAN_WIDTH-1:0]  i_line_man,
  input  logic [EXP_WIDTH-1:0]  i_line_exp,
  output logic [ADDR_WIDTH-1:0] o_man_left_wr_addr,
  output logic                  o_man_left_wr_en,
  output logic [MAN_WIDTH-1:0]  o_man_left_wr_data,
  output logic [ADDR_WIDTH-1:0] o_man_right_wr_addr,
  output logic                  o_man_right_wr_en,
  output logic [MAN_WIDTH-1:0]  o_man_right_wr_data,
  output logic [ADDR_WIDTH-1:0] o_exp_left_wr_addr,
  output logic                  o_exp_left_wr_en,
  output logic [EXP_WIDTH-1:0]  o_exp_left_wr_data,
  output logic [ADDR_WIDTH-1:0] o_exp_right_wr_addr,
  output logic                  o_exp_right_wr_en,
  output logic [EXP_WIDTH-1:0]  o_exp_right_wr_data,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(BRAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BRAM_DEPTH - 1);

  state_t                state_reg, state_next;
  logic                  side_reg, side_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;

  logic cmd_fire;
  logic beat_fire;

  assign o_cmd_ready  = (state_reg == ST_IDLE);
  assign o_line_ready = (state_reg == ST_STREAM);
  assign o_busy       = (state_reg != ST_IDLE);
  // The DONE cycle is also the cycle the last beat's write is on the ports.
  assign o_done       = (state_reg == ST_DONE);
  assign cmd_fire     = i_cmd_valid && o_cmd_ready;
  assign beat_fire    = i_line_valid && o_line_ready;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= ST_IDLE;
      side_reg      <= 1'b0;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      side_reg      <= side_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    side_next      = side_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          side_next      = i_cmd_side;
          cur_addr_next  = i_cmd_start_addr;
          // A single command can never cover more than one full side.
          remaining_next = (i_cmd_num_lines > DEPTH_CNT) ? DEPTH_CNT : i_cmd_num_lines;
          state_next     = (i_cmd_num_lines == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (beat_fire) begin
          cur_addr_next  = (cur_addr_reg == LAST_ADDR) ? '0 : cur_addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == (ADDR_WIDTH + 1)'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // One registered write port pair per side; index 0 is left, 1 is right.
  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    logic                  side_hit;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [MAN_WIDTH-1:0]  man_data_reg;
    logic [EXP_WIDTH-1:0]  exp_data_reg;

    assign side_hit = beat_fire && (side_reg == 1'(gi));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        wr_en_reg    <= 1'b0;
        wr_addr_reg  <= '0;
        man_data_reg <= '0;
        exp_data_reg <= '0;
      end else begin
        wr_en_reg <= side_hit;
        if (side_hit) begin
          wr_addr_reg  <= cur_addr_reg;
          man_data_reg <= i_line_man;
          exp_data_reg <= i_line_exp;
        end
      end
    end
  end

  assign o_man_left_wr_en    = g_side[0].wr_en_reg;
  assign o_man_left_wr_addr  = g_side[0].wr_addr_reg;
  assign o_man_left_wr_data  = g_side[0].man_data_reg;
  assign o_exp_left_wr_en    = g_side[0].wr_en_reg;
  assign o_exp_left_wr_addr  = g_side[0].wr_addr_reg;
  assign o_exp_left_wr_data  = g_side[0].exp_data_reg;

  assign o_man_right_wr_en   = g_side[1].wr_en_reg;
  assign o_man_right_wr_addr = g_side[1].wr_addr_reg;
  assign o_man_right_wr_data = g_side[1].man_data_reg;
  assign o_exp_right_wr_en   = g_side[1].wr_en_reg;
  assign o_exp_right_wr_addr = g_side[1].wr_addr_reg;
  assign o_exp_right_wr_data = g_side[1].exp_data_reg;

endmodule

// File: tb/tb_tile_dispatch_writer.sv
// Scoreboard bench for tile_dispatch_writer: drivers queue expected write/done events,
// a negedge monitor pops and compares whenever the DUT writes or pulses done.
module tb_tile_dispatch_writer;

  localparam int MW = 256;
  localparam int EW = 8;
  localparam int D  = 512;
  localparam int AW = 9;

  logic          i_clk;
  logic          i_reset_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_side;
  logic [AW-1:0] i_cmd_start_addr;
  logic [AW:0]   i_cmd_num_lines;
  logic          i_line_valid;
  logic          o_line_ready;
  logic [MW-1:0] i_line_man;
  logic [EW-1:0] i_line_exp;
  logic [AW-1:0] o_man_left_wr_addr, o_man_right_wr_addr, o_exp_left_wr_addr, o_exp_right_wr_addr;
  logic          o_man_left_wr_en, o_man_right_wr_en, o_exp_left_wr_en, o_exp_right_wr_en;
  logic [MW-1:0] o_man_left_wr_data, o_man_right_wr_data;
  logic [EW-1:0] o_exp_left_wr_data, o_exp_right_wr_data;
  logic          o_busy;
  logic          o_done;

  tile_dispatch_writer #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .BRAM_DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_side(i_cmd_side),
    .i_cmd_start_addr(i_cmd_start_addr), .i_cmd_num_lines(i_cmd_num_lines),
    .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .i_line_man(i_line_man), .i_line_exp(i_line_exp),
    .o_man_left_wr_addr(o_man_left_wr_addr), .o_man_left_wr_en(o_man_left_wr_en),
    .o_man_left_wr_data(o_man_left_wr_data),
    .o_man_right_wr_addr(o_man_right_wr_addr), .o_man_right_wr_en(o_man_right_wr_en),
    .o_man_right_wr_data(o_man_right_wr_data),
    .o_exp_left_wr_addr(o_exp_left_wr_addr), .o_exp_left_wr_en(o_exp_left_wr_en),
    .o_exp_left_wr_data(o_exp_left_wr_data),
    .o_exp_right_wr_addr(o_exp_right_wr_addr), .o_exp_right_wr_en(o_exp_right_wr_en),
    .o_exp_right_wr_data(o_exp_right_wr_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]    en;   // {man_l, exp_l, man_r, exp_r}
    logic [AW-1:0] addr;
    logic [MW-1:0] man;
    logic [EW-1:0] ex;
    logic          done;
  } ev_t;

  ev_t           exp_q[$];
  logic [EW-1:0] exp_mem_l [D];
  int            n_cmp = 0;
  int            n_bad = 0;

  logic          cur_side;
  logic [AW-1:0] cur_a;
  int            cur_rem;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, MW'(act), MW'(req));
  endtask

  // Monitor: every cycle with any write or done must match the head of the queue.
  always @(negedge i_clk) begin
    logic [3:0] en;
    ev_t        e;
    en = {o_man_left_wr_en, o_exp_left_wr_en, o_man_right_wr_en, o_exp_right_wr_en};
    if (en != 4'b0 || o_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: en=%b done=%b with nothing expected", en, o_done);
      end else begin
        e = exp_q.pop_front();
        chk("wr_en", MW'(en), MW'(e.en));
        chk1("done", o_done, e.done);
        if (e.en[3]) begin
          chk("man_l_addr", MW'(o_man_left_wr_addr), MW'(e.addr));
          chk("exp_l_addr", MW'(o_exp_left_wr_addr), MW'(e.addr));
          chk("man_l_data", o_man_left_wr_data, e.man);
          chk("exp_l_data", MW'(o_exp_left_wr_data), MW'(e.ex));
          exp_mem_l[o_exp_left_wr_addr] = o_exp_left_wr_data;
        end else if (e.en[1]) begin
          chk("man_r_addr", MW'(o_man_right_wr_addr), MW'(e.addr));
          chk("exp_r_addr", MW'(o_exp_right_wr_addr), MW'(e.addr));
          chk("man_r_data", o_man_right_wr_data, e.man);
          chk("exp_r_data", MW'(o_exp_right_wr_data), MW'(e.ex));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic issue_cmd(input logic side, input int start, input int num);
    int n = 0;
    i_cmd_valid      = 1'b1;
    i_cmd_side       = side;
    i_cmd_start_addr = AW'(start);
    i_cmd_num_lines  = (AW + 1)'(num);
    while (!o_cmd_ready && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk1("cmd_ready_wait", o_cmd_ready, 1'b1);
    cur_side = side;
    cur_a    = AW'(start);
    cur_rem  = (num > D) ? D : num;
    if (cur_rem == 0) exp_q.push_back('{en: 4'b0000, addr: '0, man: '0, ex: '0, done: 1'b1});
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    if (cur_rem == 0) chk1("zero_done_latency", o_done, 1'b1);
    else chk1("line_ready_latency", o_line_ready, 1'b1);
  endtask

  task automatic drive_beat(input logic [MW-1:0] man, input logic [EW-1:0] ex);
    int n = 0;
    i_line_valid = 1'b1;
    i_line_man   = man;
    i_line_exp   = ex;
    while (!o_line_ready && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk1("line_ready_wait", o_line_ready, 1'b1);
    exp_q.push_back('{en: cur_side ? 4'b0011 : 4'b1100, addr: cur_a, man: man, ex: ex,
                      done: (cur_rem == 1)});
    cur_a = (cur_a == AW'(D - 1)) ? '0 : cur_a + 1'b1;
    cur_rem--;
    @(posedge i_clk);
    #1;
    i_line_valid = 1'b0;
    chk1("beat_latency", cur_side ? o_man_right_wr_en : o_man_left_wr_en, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_side = 1'b0; i_cmd_start_addr = '0;
    i_cmd_num_lines = '0; i_line_valid = 1'b0; i_line_man = '0; i_line_exp = '0;
    for (int i = 0; i < D; i++) exp_mem_l[i] = 8'h00;
    #1;
    chk("rst_enables", MW'({o_man_left_wr_en, o_exp_left_wr_en, o_man_right_wr_en, o_exp_right_wr_en}), MW'(0));
    chk("rst_addr_l", MW'(o_man_left_wr_addr), MW'(0));
    chk("rst_data_r", o_man_right_wr_data, MW'(0));
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_done", o_done, 1'b0);
    chk1("rst_line_ready", o_line_ready, 1'b0);
    chk1("rst_cmd_ready", o_cmd_ready, 1'b1);
    idle(2);
    i_reset_n = 1'b1;
    idle(1);

    // Left, start 0, four back-to-back beats
    issue_cmd(1'b0, 0, 4);
    for (int i = 0; i < 4; i++) drive_beat(MW'(i + 1), 8'hA0 + 8'(i));
    idle(3);
    chk("nv0_exp", MW'({exp_mem_l[3], exp_mem_l[2], exp_mem_l[1], exp_mem_l[0]}), MW'(32'hA3A2A1A0));

    // Right, start 510, wraps to 0
    issue_cmd(1'b1, 510, 4);
    for (int i = 0; i < 4; i++) drive_beat(MW'(64'hDEAD_0000 + 64'(i)), 8'h50 + 8'(i));
    idle(3);

    // Left, start 8, valid pattern 1,0,1,0,1
    issue_cmd(1'b0, 8, 3);
    drive_beat(MW'(16'h0801), 8'h11);
    idle(1);
    drive_beat(MW'(16'h0902), 8'h22);
    idle(1);
    drive_beat(MW'(16'h0A03), 8'h33);
    idle(3);

    // Zero-count command
    issue_cmd(1'b0, 20, 0);
    idle(1);
    chk1("zero_cmd_ready_back", o_cmd_ready, 1'b1);
    idle(2);

    // 1023 saturates to one full side; a competing command is refused
    issue_cmd(1'b0, 100, 1023);
    for (int i = 0; i < D; i++) begin
      if (i == 100) begin
        i_cmd_valid = 1'b1; i_cmd_side = 1'b1; i_cmd_start_addr = AW'(7); i_cmd_num_lines = 10'd5;
      end
      if (i == 150) begin
        chk1("busy_in_stream", o_busy, 1'b1);
        chk1("cmd_ready_in_stream", o_cmd_ready, 1'b0);
      end
      if (i == 200) i_cmd_valid = 1'b0;
      drive_beat(MW'(i * 3 + 7), 8'(i));
    end
    idle(3);
    chk1("sat_back_idle", o_cmd_ready, 1'b1);

    // Reset after two of six beats
    issue_cmd(1'b1, 300, 6);
    drive_beat(MW'(32'hC0DE_0001), 8'hE1);
    drive_beat(MW'(32'hC0DE_0002), 8'hE2);
    @(negedge i_clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_enables", MW'({o_man_left_wr_en, o_exp_left_wr_en, o_man_right_wr_en, o_exp_right_wr_en}), MW'(0));
    chk1("midrst_done", o_done, 1'b0);
    chk1("midrst_busy", o_busy, 1'b0);
    chk1("midrst_line_ready", o_line_ready, 1'b0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    idle(2);
    chk1("post_rst_cmd_ready", o_cmd_ready, 1'b1);
    issue_cmd(1'b0, 40, 2);
    drive_beat(MW'(32'hF00D_0001), 8'h71);
    drive_beat(MW'(32'hF00D_0002), 8'h72);
    idle(4);

    chk("queue_empty", MW'(exp_q.size()), MW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
